// File: rtl/pulse_to_level.sv
// +--------------------------------------------------------------------------+
// | pulse_to_level: converts single-cycle event pulses into levels using     |
// | toggle, stretch or acknowledge-latched modes, flagging dropped pulses.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module pulse_to_level #(
   parameter int CNT_W  = 8,
   parameter int RETRIG = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pulse,
   input  logic [1:0]       mode,
   input  logic [CNT_W-1:0] len,
   input  logic             ack,
   input  logic             clr_miss,
   output logic             level,
   output logic             busy,
   output logic             miss
);

   localparam logic [1:0]       c_mode_stretch = 2'b01;
   localparam logic [1:0]       c_mode_latch   = 2'b10;
   localparam logic [CNT_W-1:0] c_one          = CNT_W'(1);
   localparam logic             c_retrig       = (RETRIG != 0);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_STRETCH = 2'd1,
      S_LATCH   = 2'd2
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             tog_q;
   logic             level_q;
   logic             busy_q;
   logic             miss_q;
   logic             miss_d;
   logic             miss_set;
   logic [CNT_W-1:0] len_m1;

   // A zero length behaves as one, so the reload value never underflows.
   assign len_m1 = (len == '0) ? '0 : (len - c_one);

   always_comb begin
      miss_set = 1'b0;
      case (state_q)
         S_STRETCH: miss_set = pulse && !c_retrig;
         S_LATCH:   miss_set = pulse && !ack;
         default:   miss_set = 1'b0;
      endcase
      if (miss_set) begin
         miss_d = 1'b1;
      end else if (clr_miss) begin
         miss_d = 1'b0;
      end else begin
         miss_d = miss_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         tog_q   <= 1'b0;
         level_q <= 1'b0;
         busy_q  <= 1'b0;
         miss_q  <= 1'b0;
      end else begin
         miss_q <= miss_d;
         case (state_q)
            S_IDLE: begin
               if ((mode == c_mode_stretch) || (mode == c_mode_latch)) begin
                  tog_q <= 1'b0;
                  if (pulse) begin
                     level_q <= 1'b1;
                     busy_q  <= 1'b1;
                     if (mode == c_mode_stretch) begin
                        cnt_q   <= len_m1;
                        state_q <= S_STRETCH;
                     end else begin
                        state_q <= S_LATCH;
                     end
                  end else begin
                     level_q <= 1'b0;
                     busy_q  <= 1'b0;
                  end
               end else begin
                  tog_q   <= tog_q ^ pulse;
                  level_q <= tog_q ^ pulse;
                  busy_q  <= 1'b0;
               end
            end
            S_STRETCH: begin
               // A retrigger on the final cycle reloads without a low gap.
               if (pulse && c_retrig) begin
                  cnt_q <= len_m1;
               end else if (cnt_q == '0) begin
                  level_q <= 1'b0;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else begin
                  cnt_q <= cnt_q - c_one;
               end
            end
            S_LATCH: begin
               // ack together with pulse re-latches the new event.
               if (ack && !pulse) begin
                  level_q <= 1'b0;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
               level_q <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign level = level_q;
   assign busy  = busy_q;
   assign miss  = miss_q;

endmodule

`default_nettype wire

// File: tb/tb_pulse_to_level.sv
// +--------------------------------------------------------------------------+
// | tb_pulse_to_level: directed self-checking bench; one retriggering and    |
// | one non-retriggering instance share the same stimulus.                   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_pulse_to_level;

   logic       clk;
   logic       reset;
   logic       pulse;
   logic [1:0] mode;
   logic [7:0] len;
   logic       ack;
   logic       clr_miss;
   logic       level1, busy1, miss1;
   logic       level0, busy0, miss0;

   int n_checks = 0;
   int n_fail   = 0;

   pulse_to_level #(.CNT_W(8), .RETRIG(1)) u_dut_rt (
      .clk(clk), .reset(reset), .pulse(pulse), .mode(mode), .len(len),
      .ack(ack), .clr_miss(clr_miss),
      .level(level1), .busy(busy1), .miss(miss1)
   );

   pulse_to_level #(.CNT_W(8), .RETRIG(0)) u_dut_nrt (
      .clk(clk), .reset(reset), .pulse(pulse), .mode(mode), .len(len),
      .ack(ack), .clr_miss(clr_miss),
      .level(level0), .busy(busy0), .miss(miss0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Outputs are sampled 1 time unit after the edge, then inputs may change.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Counts high cycles of both instances over n edges, pulsing at the offsets given.
   task automatic run_count(input int n, input int p_a, input int p_b,
                            output int c1, output int c0);
      c1 = 0;
      c0 = 0;
      for (int i = 0; i < n; i++) begin
         pulse = (i == p_a) || (i == p_b);
         step();
         if (level1) c1++;
         if (level0) c0++;
      end
      pulse = 1'b0;
   endtask

   int c1, c0;

   initial begin
      reset = 1'b0; pulse = 1'b0; mode = 2'b00; len = 8'd0; ack = 1'b0; clr_miss = 1'b0;
      step();
      step();
      check("reset_level", level1, 0);
      check("reset_busy",  busy1,  0);
      check("reset_miss",  miss1,  0);
      reset = 1'b1;

      // Toggle mode
      pulse = 1'b1; step(); pulse = 1'b0;
      check("tog_first", level1, 1);
      step(); step(); step();
      check("tog_hold", level1, 1);
      pulse = 1'b1; step();
      check("tog_second", level1, 0);
      step(); pulse = 1'b0;
      check("tog_third", level1, 1);
      check("tog_busy", busy1, 0);
      check("tog_miss", miss1, 0);
      mode = 2'b11; pulse = 1'b1; step(); pulse = 1'b0;
      check("tog_reserved", level1, 0);
      pulse = 1'b1; step(); pulse = 1'b0;
      check("tog_reserved2", level1, 1);
      mode = 2'b01; step();
      check("tog_to_stretch", level1, 0);

      // Stretch basic
      len = 8'd4;
      run_count(10, 0, -1, c1, c0);
      check("stretch4_rt", c1, 4);
      check("stretch4_nrt", c0, 4);
      check("stretch4_busy_end", busy1, 0);
      len = 8'd0;
      run_count(6, 0, -1, c1, c0);
      check("stretch0", c1, 1);

      // Retrigger, pulses 3 apart
      len = 8'd5;
      run_count(14, 0, 3, c1, c0);
      check("retrig_rt", c1, 8);
      check("retrig_nrt", c0, 5);
      check("retrig_rt_miss", miss1, 0);
      check("retrig_nrt_miss", miss0, 1);
      clr_miss = 1'b1; step(); clr_miss = 1'b0;
      check("retrig_clr", miss0, 0);

      // Pulse on the final stretch cycle
      len = 8'd2;
      run_count(8, 0, 2, c1, c0);
      check("final_reload_rt", c1, 4);
      check("final_drop_nrt", c0, 2);
      check("final_drop_miss", miss0, 1);
      clr_miss = 1'b1; step(); clr_miss = 1'b0;

      // Mode change mid-stretch is ignored
      len = 8'd4;
      pulse = 1'b1; step(); pulse = 1'b0;
      mode = 2'b10;
      c1 = 1;
      repeat (8) begin step(); if (level1) c1++; end
      check("mode_switch_len", c1, 4);
      check("mode_switch_busy", busy1, 0);

      // Latch handshake
      pulse = 1'b1; step(); pulse = 1'b0;
      check("latch_level", level1, 1);
      check("latch_busy", busy1, 1);
      c1 = 1;
      repeat (5) begin step(); if (level1) c1++; end
      ack = 1'b1; step(); ack = 1'b0;
      check("latch_high_len", c1, 6);
      check("latch_ack_level", level1, 0);
      check("latch_ack_busy", busy1, 0);
      pulse = 1'b1; step(); pulse = 1'b0;
      check("latch_reaccept", level1, 1);
      ack = 1'b1; pulse = 1'b1; step(); ack = 1'b0; pulse = 1'b0;
      check("latch_ackpulse_lvl", level1, 1);
      check("latch_ackpulse_miss", miss1, 0);
      step();
      check("latch_ackpulse_hold", busy1, 1);

      // Miss flag in latch
      pulse = 1'b1; step(); pulse = 1'b0;
      check("latch_miss_set", miss1, 1);
      check("latch_miss_nrt", miss0, 1);
      check("latch_miss_level", level1, 1);
      pulse = 1'b1; clr_miss = 1'b1; step(); pulse = 1'b0;
      check("miss_set_wins", miss1, 1);
      step(); clr_miss = 1'b0;
      check("miss_cleared", miss1, 0);
      ack = 1'b1; step(); ack = 1'b0;
      check("latch_exit", level1, 0);

      // Reset mid-stretch
      mode = 2'b01; len = 8'd10;
      pulse = 1'b1; step(); pulse = 1'b0;
      step(); step(); step();
      check("mid_stretch_level", level1, 1);
      reset = 1'b0; step(); reset = 1'b1;
      check("abort_level", level1, 0);
      check("abort_busy", busy1, 0);
      step(); step();
      check("abort_no_pending", level1, 0);
      check("abort_no_pending_b", busy0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
